// File: rtl/video_timing_out.sv
// Video output stage: programmable display timing, read-coordinate issue, latency realignment and RGB expansion.
// Optional: define VIDEO_OUT_REPLICATE_EN for bit-replicating colour expansion (default zero-fill).
module video_timing_out #(
    parameter int CORDW   = 10,
    parameter int H_RES   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_RES   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int R_BITS  = 3,
    parameter int G_BITS  = 4,
    parameter int B_BITS  = 3,
    parameter int PIX_LAT = 1
) (
    input  logic                             clk_pix,
    input  logic                             rst_pix,
    output logic [CORDW-1:0]                 o_rd_x,
    output logic [CORDW-1:0]                 o_rd_y,
    output logic                             o_rd_de,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]  i_color,
    output logic [CORDW-1:0]                 o_sx,
    output logic [CORDW-1:0]                 o_sy,
    output logic                             o_de,
    output logic                             o_hsync,
    output logic                             o_vsync,
    output logic                             o_frame,
    output logic [7:0]                       o_r,
    output logic [7:0]                       o_g,
    output logic [7:0]                       o_b
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_RES + H_FP;
    localparam int HS_END  = H_RES + H_FP + H_SYNC - 1;
    localparam int VS_BEG  = V_RES + V_FP;
    localparam int VS_END  = V_RES + V_FP + V_SYNC - 1;
    localparam int CW      = R_BITS + G_BITS + B_BITS;
    localparam int W       = 2 * CORDW + 3;
    localparam logic [W-1:0] FLUSH_WORD = {{(2*CORDW){1'b0}}, 1'b0, ~H_POL, ~V_POL};

    if ((H_TOTAL - 1) >= (1 << CORDW) || (V_TOTAL - 1) >= (1 << CORDW) ||
        R_BITS < 1 || R_BITS > 8 || G_BITS < 1 || G_BITS > 8 ||
        B_BITS < 1 || B_BITS > 8 || PIX_LAT < 0 || PIX_LAT > 15) begin : g_bad_cfg
        $error("video_timing_out: illegal parameter combination");
    end

    // {de, hsync, vsync} for a counter position, syncs at their configured active level
    function automatic logic [2:0] decode(input logic [CORDW-1:0] x, input logic [CORDW-1:0] y);
        logic de;
        logic hs_act;
        logic vs_act;
        de     = (x < CORDW'(H_RES)) && (y < CORDW'(V_RES));
        hs_act = (x >= CORDW'(HS_BEG)) && (x <= CORDW'(HS_END));
        vs_act = (y >= CORDW'(VS_BEG)) && (y <= CORDW'(VS_END));
        return {de, hs_act ? H_POL : ~H_POL, vs_act ? V_POL : ~V_POL};
    endfunction

    // Widen an n-bit channel (right-aligned in c) to 8 bits, MSB-first
    function automatic logic [7:0] expand(input logic [7:0] c, input int n);
        logic [7:0] e;
        int j;
        e = 8'd0;
        j = n - 1;
        for (int i = 7; i >= 0; i--) begin
`ifdef VIDEO_OUT_REPLICATE_EN
            e[i[2:0]] = c[j[2:0]];
            if (j == 0) begin
                j = n - 1;
            end else begin
                j = j - 1;
            end
`else
            if (j >= 0) begin
                e[i[2:0]] = c[j[2:0]];
            end else begin
                e[i[2:0]] = 1'b0;
            end
            j = j - 1;
`endif
        end
        return e;
    endfunction

    logic [CORDW-1:0] rd_x_q, rd_y_q, rd_x_d, rd_y_d;
    logic             rd_de_q, rd_hs_q, rd_vs_q;
    logic [W-1:0]     cnt_word_s, dly_s;

    // Next counter position: x wraps at line end, y advances on the x wrap
    always_comb begin
        rd_x_d = rd_x_q;
        rd_y_d = rd_y_q;
        if (rd_x_q == CORDW'(H_TOTAL - 1)) begin
            rd_x_d = '0;
            if (rd_y_q == CORDW'(V_TOTAL - 1)) begin
                rd_y_d = '0;
            end else begin
                rd_y_d = rd_y_q + CORDW'(1);
            end
        end else begin
            rd_x_d = rd_x_q + CORDW'(1);
        end
    end

    // Counter stage with its decoded timing fields
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rd_x_q                      <= '0;
            rd_y_q                      <= '0;
            {rd_de_q, rd_hs_q, rd_vs_q} <= decode('0, '0);
        end else begin
            rd_x_q                      <= rd_x_d;
            rd_y_q                      <= rd_y_d;
            {rd_de_q, rd_hs_q, rd_vs_q} <= decode(rd_x_d, rd_y_d);
        end
    end

    assign o_rd_x     = rd_x_q;
    assign o_rd_y     = rd_y_q;
    assign o_rd_de    = rd_de_q;
    assign cnt_word_s = {rd_x_q, rd_y_q, rd_de_q, rd_hs_q, rd_vs_q};

    if (PIX_LAT == 0) begin : g_no_delay
        assign dly_s = cnt_word_s;
    end else begin : g_delay
        logic [W-1:0] dl_q [PIX_LAT];

        // Timing delay line matching the renderer's read latency
        always_ff @(posedge clk_pix) begin
            if (rst_pix) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    dl_q[i] <= FLUSH_WORD;
                end
            end else begin
                dl_q[0] <= cnt_word_s;
                for (int i = 1; i < PIX_LAT; i++) begin
                    dl_q[i] <= dl_q[i-1];
                end
            end
        end

        assign dly_s = dl_q[PIX_LAT-1];
    end

    logic [CORDW-1:0] d_x_s, d_y_s;
    logic             d_de_s, d_hs_s, d_vs_s;
    logic [7:0]       r_s, g_s, b_s;

    assign d_x_s  = dly_s[W-1 -: CORDW];
    assign d_y_s  = dly_s[W-1-CORDW -: CORDW];
    assign d_de_s = dly_s[2];
    assign d_hs_s = dly_s[1];
    assign d_vs_s = dly_s[0];
    assign r_s    = expand(8'(i_color[CW-1 -: R_BITS]), R_BITS);
    assign g_s    = expand(8'(i_color[B_BITS +: G_BITS]), G_BITS);
    assign b_s    = expand(8'(i_color[0 +: B_BITS]), B_BITS);

    // Output register: colour joins its delayed timing; blanked outside the active area
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            o_sx    <= '0;
            o_sy    <= '0;
            o_de    <= 1'b0;
            o_hsync <= ~H_POL;
            o_vsync <= ~V_POL;
            o_frame <= 1'b0;
            o_r     <= 8'd0;
            o_g     <= 8'd0;
            o_b     <= 8'd0;
        end else begin
            o_sx    <= d_x_s;
            o_sy    <= d_y_s;
            o_de    <= d_de_s;
            o_hsync <= d_hs_s;
            o_vsync <= d_vs_s;
            // Flushed stages carry de=0, so a post-reset (0,0) never raises frame
            o_frame <= d_de_s && (d_x_s == '0) && (d_y_s == '0);
            o_r     <= d_de_s ? r_s : 8'd0;
            o_g     <= d_de_s ? g_s : 8'd0;
            o_b     <= d_de_s ? b_s : 8'd0;
        end
    end

endmodule

// File: tb/tb_video_timing_out.sv
// Bench for video_timing_out: small raster (14x7), PIX_LAT=2, both sync polarities side by side.
module tb_video_timing_out;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FR = HT * VT;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic [9:0] i_color = 10'd0;

    logic [9:0] rd_x0, rd_y0, sx0, sy0, rd_x1, rd_y1, sx1, sy1;
    logic       rd_de0, de0, hs0, vs0, fr0, rd_de1, de1, hs1, vs1, fr1;
    logic [7:0] r0, g0, b0, r1, g1, b1;

    video_timing_out #(.CORDW(10), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0),
        .R_BITS(3), .G_BITS(4), .B_BITS(3), .PIX_LAT(2)) dut0 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .o_rd_x(rd_x0), .o_rd_y(rd_y0),
        .o_rd_de(rd_de0), .i_color(i_color), .o_sx(sx0), .o_sy(sy0), .o_de(de0),
        .o_hsync(hs0), .o_vsync(vs0), .o_frame(fr0), .o_r(r0), .o_g(g0), .o_b(b0));

    video_timing_out #(.CORDW(10), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1),
        .R_BITS(3), .G_BITS(4), .B_BITS(3), .PIX_LAT(2)) dut1 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .o_rd_x(rd_x1), .o_rd_y(rd_y1),
        .o_rd_de(rd_de1), .i_color(i_color), .o_sx(sx1), .o_sy(sy1), .o_de(de1),
        .o_hsync(hs1), .o_vsync(vs1), .o_frame(fr1), .o_r(r1), .o_g(g1), .o_b(b1));

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int cyc;
        int sx, sy, de, r, g, b, hs, vs, fr;
    } vec_t;

    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    int   c = 0;
    int   mem[HT][VT];
    int   drv[1024];
    int   last_fr = -1;
    logic prev_fr = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at c=%0d: actual=%0d required=%0d", nm, c, act, exp);
        end
    endfunction

    // Reference expansion: zero-fill is a left shift; replication takes the top byte of c repeated
    function automatic int exp8(input int v, input int n);
        longint rep;
`ifdef VIDEO_OUT_REPLICATE_EN
        rep = 0;
        for (int k = 0; k < 8; k++) rep = (rep << n) | longint'(v);
        return int'((rep >> (8 * n - 8)) & 255);
`else
        rep = longint'(v) << (8 - n);
        return int'(rep & 255);
`endif
    endfunction

    function automatic void check_cycle();
        int p, q, x, y, de, col;
        p = c % FR;
        chk("rd_x", int'(rd_x0), p % HT);
        chk("rd_y", int'(rd_y0), p / HT);
        chk("rd_de", int'(rd_de0), int'((p % HT) < 8 && (p / HT) < 4));
        if (c < 3) begin
            chk("fill_sx", int'(sx0), 0);  chk("fill_sy", int'(sy0), 0);
            chk("fill_de", int'(de0), 0);  chk("fill_fr", int'(fr0), 0);
            chk("fill_rgb", int'({r0, g0, b0}), 0);
            chk("fill_hs", int'(hs0), 1);  chk("fill_vs", int'(vs0), 1);
            chk("fill_hs_p1", int'(hs1), 0); chk("fill_vs_p1", int'(vs1), 0);
        end else begin
            q   = (c - 3) % FR;
            x   = q % HT;
            y   = q / HT;
            de  = int'(x < 8 && y < 4);
            col = drv[c-1];
            chk("sx", int'(sx0), x);
            chk("sy", int'(sy0), y);
            chk("de", int'(de0), de);
            chk("hsync", int'(hs0), int'(!(x == 10 || x == 11)));
            chk("vsync", int'(vs0), int'(y != 5));
            chk("hsync_pol1", int'(hs1), int'(x == 10 || x == 11));
            chk("vsync_pol1", int'(vs1), int'(y == 5));
            chk("frame", int'(fr0), int'(q == 0));
            chk("r", int'(r0), de ? exp8((col >> 7) & 7, 3) : 0);
            chk("g", int'(g0), de ? exp8((col >> 3) & 15, 4) : 0);
            chk("b", int'(b0), de ? exp8(col & 7, 3) : 0);
        end
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].cyc == c) begin
                chk("tbl_sx", int'(sx0), tbl[i].sx);  chk("tbl_sy", int'(sy0), tbl[i].sy);
                chk("tbl_de", int'(de0), tbl[i].de);  chk("tbl_r", int'(r0), tbl[i].r);
                chk("tbl_g", int'(g0), tbl[i].g);     chk("tbl_b", int'(b0), tbl[i].b);
                chk("tbl_hs", int'(hs0), tbl[i].hs);  chk("tbl_vs", int'(vs0), tbl[i].vs);
                chk("tbl_fr", int'(fr0), tbl[i].fr);
            end
        end
        if (c == 0) begin
            last_fr = -1;
            prev_fr = 1'b0;
        end
        if (fr0) begin
            if (last_fr >= 0) chk("frame_period", c - last_fr, FR);
            chk("frame_width", int'(prev_fr), 0);
            last_fr = c;
        end
        prev_fr = fr0;
    endfunction

    // Renderer model: colour for the coordinate issued two cycles earlier
    task automatic drive();
        int p;
        if (c >= 2) begin
            p = (c - 2) % FR;
            drv[c] = mem[p % HT][p / HT];
        end else begin
            drv[c] = int'($urandom_range(1023, 0));
        end
        i_color = 10'(drv[c]);
    endtask

    task automatic run(input int ncyc, input int rst_at);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk_pix); #1;
            if (rst_pix) begin
                rst_pix = 1'b0;
                c = 0;
            end else begin
                c++;
            end
            check_cycle();
            drive();
            if (c == rst_at) begin
                chk("prerst_rd_x", int'(rd_x0), 6);
                chk("prerst_rd_y", int'(rd_y0), 2);
                rst_pix = 1'b1;
            end
        end
    endtask

    initial begin
        for (int x = 0; x < HT; x++)
            for (int y = 0; y < VT; y++)
                mem[x][y] = (x < 8 && y < 4) ? int'($urandom_range(1023, 0)) : 1023;
        mem[3][1] = 10'b101_0110_101;

`ifdef VIDEO_OUT_REPLICATE_EN
        tbl[0] = '{20, 3, 1, 1, 8'hB6, 8'h66, 8'hB6, 1, 1, 0};
`else
        tbl[0] = '{20, 3, 1, 1, 8'hA0, 8'h60, 8'hA0, 1, 1, 0};
`endif
        tbl[1] = '{11, 8, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[2] = '{13, 10, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{14, 11, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[4] = '{15, 12, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{73, 0, 5, 0, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{100, 13, 6, 0, 0, 0, 0, 1, 1, 0};
        tbl[7] = '{2, 0, 0, 0, 0, 0, 0, 1, 1, 0};

        // Reset held for five edges; colour input is garbage throughout
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_pix); #1;
            i_color = 10'($urandom_range(1023, 0));
            chk("rst_rd_x", int'(rd_x0), 0);   chk("rst_rd_y", int'(rd_y0), 0);
            chk("rst_sx", int'(sx0), 0);       chk("rst_sy", int'(sy0), 0);
            chk("rst_de", int'(de0), 0);       chk("rst_fr", int'(fr0), 0);
            chk("rst_rgb", int'({r0, g0, b0}), 0);
            chk("rst_hs", int'(hs0), 1);       chk("rst_vs", int'(vs0), 1);
            chk("rst_hs_p1", int'(hs1), 0);    chk("rst_vs_p1", int'(vs1), 0);
        end
        rst_pix = 1'b0;
        c = 0;
        check_cycle();
        drive();

        // First frame and a bit, then a one-cycle reset at counter (6,2)
        run(200, FR + 2 * HT + 6);
        // Restart after the mid-frame reset and free run three frames
        run(3 * FR + 10, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
